// File: rtl/makestuff_ram_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | makestuff_ram_pkg: shared FSM state and parameter checks, rev 1.0  |
// +--------------------------------------------------------------------+
package makestuff_ram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  function automatic bit rd_latency_legal(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/makestuff_ram_sc_be_store.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | makestuff_ram_sc_be_store: byte-enable array, read-first, rev 1.0  |
// +--------------------------------------------------------------------+
module makestuff_ram_sc_be_store #(
  parameter int ADDR_NBITS = 5,
  parameter int SPAN_NBITS = 8,
  parameter int NUM_SPANS  = 8
) (
  input  logic                            clk_in,
  input  logic                            wr_en,
  input  logic [NUM_SPANS-1:0]            wr_mask,
  input  logic [ADDR_NBITS-1:0]           wr_addr,
  input  logic [NUM_SPANS*SPAN_NBITS-1:0] wr_data,
  input  logic                            rd_en,
  input  logic [ADDR_NBITS-1:0]           rd_addr,
  output logic [NUM_SPANS*SPAN_NBITS-1:0] rd_data
);

  localparam int C_DEPTH    = 2**ADDR_NBITS;
  localparam int C_ROW_BITS = NUM_SPANS*SPAN_NBITS;

  logic [C_ROW_BITS-1:0] r_mem [C_DEPTH];
  logic [C_ROW_BITS-1:0] r_rd_data;

  // Non-blocking read and write in one process gives read-first ordering.
  always_ff @(posedge clk_in) begin
    if (rd_en)
      r_rd_data <= r_mem[rd_addr];
    if (wr_en && !$isunknown(wr_addr)) begin
      for (int i = 0; i < NUM_SPANS; i++) begin
        if (wr_mask[i])
          r_mem[wr_addr][i*SPAN_NBITS +: SPAN_NBITS] <= wr_data[i*SPAN_NBITS +: SPAN_NBITS];
      end
    end
  end

  assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/makestuff_ram_sc_be_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | makestuff_ram_sc_be_pipe: masked RAM, clear engine, fwd, rev 1.0   |
// +--------------------------------------------------------------------+
module makestuff_ram_sc_be_pipe
  import makestuff_ram_pkg::*;
#(
  parameter int                    ADDR_NBITS = 5,
  parameter int                    SPAN_NBITS = 8,
  parameter int                    NUM_SPANS  = 8,
  parameter int                    RD_LATENCY = 1,
  parameter int                    FORWARD    = 1,
  parameter logic [SPAN_NBITS-1:0] INIT_SPAN  = '0
) (
  input  logic                            clk_in,
  input  logic                            reset_in,
  input  logic                            clear_in,
  output logic                            ready_out,
  input  logic                            wrValid_in,
  input  logic [NUM_SPANS-1:0]            wrMask_in,
  input  logic [ADDR_NBITS-1:0]           wrAddr_in,
  input  logic [NUM_SPANS*SPAN_NBITS-1:0] wrData_in,
  input  logic                            rdValid_in,
  input  logic [ADDR_NBITS-1:0]           rdAddr_in,
  output logic [NUM_SPANS*SPAN_NBITS-1:0] rdData_out,
  output logic                            rdValid_out
);

  localparam int                    C_ROW_BITS = NUM_SPANS*SPAN_NBITS;
  localparam logic [ADDR_NBITS-1:0] C_LAST_ROW = '1;

  if (!rd_latency_legal(RD_LATENCY)) begin : g_bad_latency
    $error("RD_LATENCY must be 1 or 2");
  end

  state_t                  r_state, w_state_next;
  logic [ADDR_NBITS-1:0]   r_clr_addr, w_clr_addr_next;
  logic                    w_ready;
  logic                    w_in_clear, w_wr_issue, w_rd_issue;
  logic                    r_rd_valid1;
  logic [NUM_SPANS-1:0]    r_fwd_mask;
  logic [C_ROW_BITS-1:0]   r_fwd_data;
  logic [C_ROW_BITS-1:0]   w_store_q, w_s1_data;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state    <= CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_next;
      r_clr_addr <= w_clr_addr_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_clr_addr_next = r_clr_addr;
    w_ready         = 1'b0;
    case (r_state)
      CLEAR: begin
        w_clr_addr_next = r_clr_addr + 1'b1;
        if (r_clr_addr == C_LAST_ROW)
          w_state_next = READY;
      end
      READY: begin
        w_ready = 1'b1;
        if (clear_in)
          w_state_next = CLEAR;
      end
      default: w_state_next = CLEAR;
    endcase
  end

  assign ready_out  = w_ready;
  assign w_in_clear = (r_state == CLEAR);
  assign w_wr_issue = w_ready & wrValid_in;
  assign w_rd_issue = w_ready & rdValid_in;

  makestuff_ram_sc_be_store #(
    .ADDR_NBITS (ADDR_NBITS),
    .SPAN_NBITS (SPAN_NBITS),
    .NUM_SPANS  (NUM_SPANS)
  ) u_store (
    .clk_in  (clk_in),
    .wr_en   (w_in_clear | w_wr_issue),
    .wr_mask (w_in_clear ? {NUM_SPANS{1'b1}} : wrMask_in),
    .wr_addr (w_in_clear ? r_clr_addr : wrAddr_in),
    .wr_data (w_in_clear ? {NUM_SPANS{INIT_SPAN}} : wrData_in),
    .rd_en   (w_rd_issue),
    .rd_addr (rdAddr_in),
    .rd_data (w_store_q)
  );

  // Same-row bypass is decided at issue and applied after the array output.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_rd_valid1 <= 1'b0;
      r_fwd_mask  <= '0;
      r_fwd_data  <= '0;
    end else begin
      r_rd_valid1 <= w_rd_issue;
      if (w_rd_issue) begin
        r_fwd_mask <= ((FORWARD != 0) && w_wr_issue && (wrAddr_in == rdAddr_in)) ?
                      wrMask_in : '0;
        r_fwd_data <= wrData_in;
      end
    end
  end

  always_comb begin
    w_s1_data = w_store_q;
    for (int i = 0; i < NUM_SPANS; i++) begin
      if (r_fwd_mask[i])
        w_s1_data[i*SPAN_NBITS +: SPAN_NBITS] = r_fwd_data[i*SPAN_NBITS +: SPAN_NBITS];
    end
  end

  if (RD_LATENCY == 1) begin : g_lat1
    // The array output has no reset, so gate it until the first read lands.
    logic r_has_data;
    always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in)
        r_has_data <= 1'b0;
      else if (w_rd_issue)
        r_has_data <= 1'b1;
    end
    assign rdData_out  = r_has_data ? w_s1_data : '0;
    assign rdValid_out = r_rd_valid1;
  end else begin : g_lat2
    logic                  r_rd_valid2;
    logic [C_ROW_BITS-1:0] r_rd_data2;
    always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
        r_rd_valid2 <= 1'b0;
        r_rd_data2  <= '0;
      end else begin
        r_rd_valid2 <= r_rd_valid1;
        if (r_rd_valid1)
          r_rd_data2 <= w_s1_data;
      end
    end
    assign rdData_out  = r_rd_data2;
    assign rdValid_out = r_rd_valid2;
  end

endmodule
`default_nettype wire
